// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: access beat, data word and arbiter state.
package sdram_port_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 10;
  localparam int STAT_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  // One beat of an SDRAM access as presented by a requester.
  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    data_t             data;
  } dram_access_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly after
// i_last (wrapping) as a one-hot vector, or zero when nobody requests.
module sdram_rr_pick #(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0]         i_req,
  input  logic [$clog2(N_PORTS)-1:0] i_last,
  output logic [N_PORTS-1:0]         o_pick
);

  localparam int IW = $clog2(N_PORTS);

  // Scan the ports in priority order starting just after the last grant.
  always_comb begin
    int   w_idx;
    logic w_found;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 1; off <= N_PORTS; off++) begin
      w_idx = int'(i_last) + off;
      if (w_idx >= N_PORTS) w_idx = w_idx - N_PORTS;
      if (!w_found && i_req[w_idx[IW-1:0]]) begin
        o_pick[w_idx[IW-1:0]] = 1'b1;
        w_found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between N_PORTS burst
// requesters. A grant is held for one BURST-beat transaction (or until the
// requester drops its request) and is followed by exactly one idle cycle.
// Optional per-port statistics counters: define SDRAM_ARB_STATS_EN.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int BURST   = 8
) (
  input  logic                CLK,
  input  logic                RESET_N_IN,
  input  logic [N_PORTS-1:0]  UP_REQ_IN,
  input  logic [N_PORTS-1:0]  UP_WRITE_IN,
  input  dram_access_t        UP_ACS_IN      [N_PORTS],
  output logic [N_PORTS-1:0]  UP_ACK_OUT,
  output data_t               UP_DATA_OUT    [N_PORTS],
  output logic                DN_REQ_OUT,
  output logic                DN_WRITE_OUT,
  output dram_access_t        DN_ACS_OUT,
  input  data_t               DN_DATA_IN,
  input  logic                DN_ACK_IN,
`ifdef SDRAM_ARB_STATS_EN
  output logic [STAT_W-1:0]   STAT_BEATS_OUT [N_PORTS],
  output logic [STAT_W-1:0]   STAT_WAIT_OUT  [N_PORTS],
`endif
  output logic [N_PORTS-1:0]  GRANT_OUT
);

  localparam int IW = $clog2(N_PORTS);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
  localparam logic [IW-1:0] LAST_PORT = IW'(N_PORTS - 1);

  arb_state_t          r_state;
  logic [N_PORTS-1:0]  r_grant;
  logic [IW-1:0]       r_gidx;
  logic [IW-1:0]       r_last;
  logic [CW-1:0]       r_beat;

  logic [N_PORTS-1:0]  w_pick;
  logic [IW-1:0]       w_pick_idx;
  logic                w_busy;
  logic                w_req_g;

  sdram_rr_pick #(
    .N_PORTS (N_PORTS)
  ) u_pick (
    .i_req  (UP_REQ_IN),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  // Binary index of the one-hot pick, stored alongside the grant for muxing.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_pick[i]) w_pick_idx = IW'(i);
    end
  end

  assign w_busy  = (r_state == ARB_BUSY);
  assign w_req_g = UP_REQ_IN[r_gidx];

  // Downstream command path is a straight mux from the granted port.
  assign DN_REQ_OUT   = w_busy & w_req_g;
  assign DN_WRITE_OUT = UP_WRITE_IN[r_gidx];
  assign DN_ACS_OUT   = UP_ACS_IN[r_gidx];
  assign UP_ACK_OUT   = (w_busy && DN_ACK_IN) ? r_grant : '0;
  assign GRANT_OUT    = r_grant;

  // Read data is broadcast unregistered; only the acked port consumes it.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) UP_DATA_OUT[i] = DN_DATA_IN;
  end

  // Arbitration FSM: pick in IDLE, hold the grant for a burst in BUSY.
  always_ff @(posedge CLK or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= LAST_PORT;
      r_beat  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        ARB_IDLE: begin
          if (|UP_REQ_IN) begin
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (DN_ACK_IN) begin
            if (r_beat == LAST_BEAT) begin
              r_state <= ARB_IDLE;
              r_grant <= '0;
              r_beat  <= '0;
              r_last  <= r_gidx;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end else if (!w_req_g) begin
            // Requester abandoned the burst before it completed.
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_beat  <= '0;
            r_last  <= r_gidx;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
          r_beat  <= '0;
        end
      endcase
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_beats [N_PORTS];
  logic [STAT_W-1:0] r_stat_wait  [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_stat
    // Saturating per-port counters of acked beats and cycles spent waiting.
    always_ff @(posedge CLK or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
        r_stat_beats[g] <= '0;
        r_stat_wait[g]  <= '0;
      end else begin
        if (UP_ACK_OUT[g] && (r_stat_beats[g] != '1)) begin
          r_stat_beats[g] <= r_stat_beats[g] + 1'b1;
        end
        if (UP_REQ_IN[g] && !r_grant[g] && (r_stat_wait[g] != '1)) begin
          r_stat_wait[g] <= r_stat_wait[g] + 1'b1;
        end
      end
    end

    assign STAT_BEATS_OUT[g] = r_stat_beats[g];
    assign STAT_WAIT_OUT[g]  = r_stat_wait[g];
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (4 ports, 8-beat bursts).
// Statistics checks are compiled in when SDRAM_ARB_STATS_EN is defined.
module tb_sdram_port_arbiter;
  import sdram_port_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int BL = 8;

  logic          CLK;
  logic          RESET_N_IN;
  logic [NP-1:0] up_req;
  logic [NP-1:0] up_write;
  dram_access_t  up_acs  [NP];
  logic [NP-1:0] up_ack;
  data_t         up_data [NP];
  logic          dn_req;
  logic          dn_write;
  dram_access_t  dn_acs;
  data_t         dn_data;
  logic          dn_ack;
  logic [NP-1:0] grant;
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0]   stat_beats [NP];
  logic [31:0]   stat_wait  [NP];
`endif

  int checks   = 0;
  int failures = 0;

  sdram_port_arbiter #(.N_PORTS(NP), .BURST(BL)) dut (
    .CLK          (CLK),
    .RESET_N_IN   (RESET_N_IN),
    .UP_REQ_IN    (up_req),
    .UP_WRITE_IN  (up_write),
    .UP_ACS_IN    (up_acs),
    .UP_ACK_OUT   (up_ack),
    .UP_DATA_OUT  (up_data),
    .DN_REQ_OUT   (dn_req),
    .DN_WRITE_OUT (dn_write),
    .DN_ACS_OUT   (dn_acs),
    .DN_DATA_IN   (dn_data),
    .DN_ACK_IN    (dn_ack),
`ifdef SDRAM_ARB_STATS_EN
    .STAT_BEATS_OUT (stat_beats),
    .STAT_WAIT_OUT  (stat_wait),
`endif
    .GRANT_OUT    (grant)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; returns at the falling edge where inputs are driven.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N_IN = 1'b0;
    up_req = '0; up_write = '0; dn_ack = 1'b0; dn_data = '0;
    tick(); tick();
    RESET_N_IN = 1'b1;
    tick();
  endtask

  // Controller acks `beats` consecutive cycles on granted port p.
  task automatic burst(input int p, input int beats);
    data_t d;
    for (int b = 0; b < beats; b++) begin
      d = 16'h1000 + 16'(p * 16 + b);
      dn_ack = 1'b1; dn_data = d;
      #1;
      check("burst_ack",   up_ack, 64'(1 << p));
      check("burst_grant", grant,  64'(1 << p));
      check("burst_dnreq", dn_req, 1);
      check("burst_data",  up_data[p], d);
      check("bcast_data",  up_data[(p + 1) % NP], d);
      tick();
    end
    dn_ack = 1'b0;
  endtask

  // Ports 0,1,3 request continuously; n grants are expected in order 0,1,3,...
  task automatic rr_sequence(input int n);
    int seq [3];
    seq[0] = 0; seq[1] = 1; seq[2] = 3;
    up_req = 4'b1011;
    #1 check("rr_latency", grant, 0);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        #1;
        check("rr_bubble_grant", grant, 0);
        check("rr_bubble_dnreq", dn_req, 0);
      end
      tick();
      check("rr_grant", grant, 64'(1 << seq[k % 3]));
      burst(seq[k % 3], BL);
    end
    up_req = '0;
    #1 check("rr_end_grant", grant, 0);
  endtask

  initial begin
    dram_access_t exp_acs;
    for (int i = 0; i < NP; i++) begin
      up_acs[i] = '{bank: 2'(i), row: 13'(100 * i + 7), col: 10'h3F0 + 10'(i), data: 16'hD000 + 16'(i)};
    end

    // Reset state
    RESET_N_IN = 1'b0;
    up_req = '0; up_write = '0; dn_ack = 1'b1; dn_data = '0;
    #2;
    check("rst_grant", grant, 0);
    check("rst_dnreq", dn_req, 0);
    check("rst_ack",   up_ack, 0);
    do_reset();

    // 1: port 2 alone, read burst, 8 back-to-back acks
    up_req[2] = 1'b1;
    #1 check("t1_latency", grant, 0);
    tick();
    check("t1_grant", grant, 4'b0100);
    check("t1_dir",   dn_write, 0);
    burst(2, BL);
    up_req = '0;
    #1;
    check("t1_end_grant", grant, 0);
    check("t1_end_dnreq", dn_req, 0);
    dn_ack = 1'b1;
    #1 check("t1_idle_ack", up_ack, 0);
    tick();
    check("t1_idle_stay", grant, 0);
    dn_ack = 1'b0;

    // 2: ports 0,1,3 together, grants 0,1,3,0 with one idle bubble
    do_reset();
    rr_sequence(4);

    // 3: port 1 write burst, ack every second cycle, address tracked per beat
    up_req[1] = 1'b1; up_write[1] = 1'b1;
    #1 check("t3_latency", grant, 0);
    tick();
    for (int b = 0; b < BL; b++) begin
      up_acs[1].col = 10'(b);
      exp_acs = '{bank: 2'd1, row: 13'd107, col: 10'(b), data: 16'hD001};
      dn_ack = 1'b0;
      #1;
      check("t3_gap_grant", grant, 4'b0010);
      check("t3_gap_ack",   up_ack, 0);
      check("t3_acs",       dn_acs, exp_acs);
      check("t3_dir",       dn_write, 1);
      tick();
      dn_ack = 1'b1;
      #1 check("t3_ack", up_ack, 4'b0010);
      tick();
    end
    dn_ack = 1'b0;
    #1 check("t3_end_grant", grant, 0);
    up_req = '0; up_write = '0;

    // 4: port 0 drops after 3 acks, waiting port 1 follows
    up_req = 4'b0011;
    tick();
    check("t4_grant0", grant, 4'b0001);
    burst(0, 3);
    up_req[0] = 1'b0;
    #1;
    check("t4_drop_dnreq", dn_req, 0);
    check("t4_drop_hold",  grant, 4'b0001);
    tick();
    check("t4_abort_idle", grant, 0);
    tick();
    check("t4_grant1", grant, 4'b0010);
    burst(1, BL);
    #1 check("t4_full_burst_end", grant, 0);
    up_req = '0;

    // 5: async reset in the middle of a burst on port 2
    up_req = 4'b0101;
    tick();
    check("t5_grant2", grant, 4'b0100);
    burst(2, 4);
    dn_ack = 1'b1;
    #1 check("t5_pre_rst_ack", up_ack, 4'b0100);
    RESET_N_IN = 1'b0;
    #1;
    check("t5_rst_grant", grant, 0);
    check("t5_rst_dnreq", dn_req, 0);
    check("t5_rst_ack",   up_ack, 0);
    #2 RESET_N_IN = 1'b1;
    dn_ack = 1'b0;
    tick();
    check("t5_post_rst_grant", grant, 4'b0001);
    burst(0, BL);
    up_req = '0;
    #1 check("t5_end_grant", grant, 0);

`ifdef SDRAM_ARB_STATS_EN
    // 6: three rounds of ports 0,1,3; each port waits 6 bursts * 8 + 9 bubbles
    do_reset();
    for (int i = 0; i < NP; i++) begin
      check("t6_rst_beats", stat_beats[i], 0);
      check("t6_rst_wait",  stat_wait[i], 0);
    end
    rr_sequence(9);
    tick();
    check("t6_beats0", stat_beats[0], 24);
    check("t6_beats1", stat_beats[1], 24);
    check("t6_beats2", stat_beats[2], 0);
    check("t6_beats3", stat_beats[3], 24);
    check("t6_wait0",  stat_wait[0], 57);
    check("t6_wait1",  stat_wait[1], 57);
    check("t6_wait2",  stat_wait[2], 0);
    check("t6_wait3",  stat_wait[3], 57);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
